// File: rtl/cpu_define.sv
// Shared CPU-wide widths, tag constants and the operand snoop helper used by
// the reservation stations.
package cpu_define;

  localparam int OP_W    = 6;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int RS_SIZE = 16;

  typedef logic [OP_W-1:0]   OPBus;
  typedef logic [TAG_W-1:0]  TagBus;
  typedef logic [DATA_W-1:0] DataBus;

  localparam TagBus Null    = 5'd0;
  localparam logic  Valid   = 1'b1;
  localparam logic  Invalid = 1'b0;
  localparam logic  Enable  = 1'b1;
  localparam logic  Disable = 1'b0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_XOR = 6'd3
  } alu_op_e;

  typedef struct packed {
    logic   valid;
    TagBus  tag;
    DataBus data;
  } cdb_t;

  typedef struct packed {
    logic   valid;
    DataBus data;
    TagBus  tag;
  } operand_t;

  typedef struct packed {
    logic     busy;
    OPBus     op;
    DataBus   imm;
    DataBus   pc;
    TagBus    dest;
    operand_t r1;
    operand_t r2;
  } rs_entry_t;

  // ALU broadcast wins if both buses carry the same tag; Null never matches.
  function automatic operand_t snoop(input operand_t opnd, input cdb_t alu, input cdb_t lsb);
    operand_t res;
    res = opnd;
    if (!opnd.valid && alu.valid && (alu.tag != Null) && (alu.tag == opnd.tag)) begin
      res.valid = Valid;
      res.data  = alu.data;
    end else if (!opnd.valid && lsb.valid && (lsb.tag != Null) && (lsb.tag == opnd.tag)) begin
      res.valid = Valid;
      res.data  = lsb.data;
    end else begin
      res = opnd;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder: reports whether any request is set and the
// index of the lowest one.
module alu_rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest set request is written last.
  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = req_i[i] ? IDX_W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands arrive on
// the CDBs, then issues the lowest-index ready entry to the ALU.
module alu_rs
  import cpu_define::*;
#(
  parameter int RS_SIZE = cpu_define::RS_SIZE
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   rdy_in,
  input  logic   clear_in,
  input  logic   DP_enable,
  input  OPBus   DP_op,
  input  DataBus DP_imm,
  input  DataBus DP_pc,
  input  logic   DP_reg1_valid,
  input  DataBus DP_reg1_data,
  input  TagBus  DP_reg1_tag,
  input  logic   DP_reg2_valid,
  input  DataBus DP_reg2_data,
  input  TagBus  DP_reg2_tag,
  input  TagBus  DP_reg_dest_tag,
  output logic   full_out,
  input  logic   CDB_ALU_valid,
  input  TagBus  CDB_ALU_tag,
  input  DataBus CDB_ALU_data,
  input  logic   CDB_LSB_valid,
  input  TagBus  CDB_LSB_tag,
  input  DataBus CDB_LSB_data,
  output logic   ALU_enable,
  output OPBus   ALU_op,
  output DataBus ALU_reg1,
  output DataBus ALU_reg2,
  output DataBus ALU_imm,
  output DataBus ALU_pc,
  output TagBus  ALU_reg_dest_tag
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t [RS_SIZE-1:0] ent_q, ent_d, ent_rst_s;
  logic      [RS_SIZE-1:0] free_s, ready_s;
  logic                    free_found_s, issue_found_s, ins_s;
  logic      [IDX_W-1:0]   free_idx_s, issue_idx_s;
  logic      [CNT_W-1:0]   cnt_s;
  cdb_t                    cdb_alu_s, cdb_lsb_s;
  operand_t                dp_r1_s, dp_r2_s;
  rs_entry_t               new_s;

  logic   alu_en_q, alu_en_d, full_q, full_d;
  OPBus   alu_op_q, alu_op_d;
  DataBus alu_r1_q, alu_r1_d, alu_r2_q, alu_r2_d, alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
  TagBus  alu_dest_q, alu_dest_d;

  assign cdb_alu_s = {CDB_ALU_valid, CDB_ALU_tag, CDB_ALU_data};
  assign cdb_lsb_s = {CDB_LSB_valid, CDB_LSB_tag, CDB_LSB_data};
  assign dp_r1_s   = snoop({DP_reg1_valid, DP_reg1_data, DP_reg1_tag}, cdb_alu_s, cdb_lsb_s);
  assign dp_r2_s   = snoop({DP_reg2_valid, DP_reg2_data, DP_reg2_tag}, cdb_alu_s, cdb_lsb_s);
  assign new_s     = {Valid, DP_op, DP_imm, DP_pc, DP_reg_dest_tag, dp_r1_s, dp_r2_s};
  assign ins_s     = DP_enable & free_found_s;

  // Readiness uses operand state at the start of the cycle, so a fresh insert
  // cannot issue until the following cycle.
  always_comb begin
    ent_rst_s = ent_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_s[i]              = ~ent_q[i].busy;
      ready_s[i]             = ent_q[i].busy & ent_q[i].r1.valid & ent_q[i].r2.valid;
      ent_rst_s[i].busy      = Invalid;
      ent_rst_s[i].r1.valid  = Invalid;
      ent_rst_s[i].r2.valid  = Invalid;
    end
  end

  alu_rs_select #(.N(RS_SIZE)) u_free_sel (
    .req_i   (free_s),
    .found_o (free_found_s),
    .idx_o   (free_idx_s)
  );

  alu_rs_select #(.N(RS_SIZE)) u_issue_sel (
    .req_i   (ready_s),
    .found_o (issue_found_s),
    .idx_o   (issue_idx_s)
  );

  always_comb begin
    ent_d      = ent_q;
    alu_en_d   = Disable;
    alu_op_d   = alu_op_q;
    alu_r1_d   = alu_r1_q;
    alu_r2_d   = alu_r2_q;
    alu_imm_d  = alu_imm_q;
    alu_pc_d   = alu_pc_q;
    alu_dest_d = alu_dest_q;
    full_d     = full_q;
    cnt_s      = '0;
    if (!rdy_in) begin
      alu_en_d = Disable;
    end else if (clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_d[i].busy = Invalid;
      end
      full_d = 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_d[i].r1 = ent_q[i].busy ? snoop(ent_q[i].r1, cdb_alu_s, cdb_lsb_s) : ent_q[i].r1;
        ent_d[i].r2 = ent_q[i].busy ? snoop(ent_q[i].r2, cdb_alu_s, cdb_lsb_s) : ent_q[i].r2;
        if (issue_found_s && (issue_idx_s == IDX_W'(i))) begin
          ent_d[i].busy = Invalid;
        end else if (ins_s && (free_idx_s == IDX_W'(i))) begin
          ent_d[i] = new_s;
        end else begin
          ent_d[i].busy = ent_q[i].busy;
        end
      end
      if (issue_found_s) begin
        alu_en_d   = Enable;
        alu_op_d   = ent_q[issue_idx_s].op;
        alu_r1_d   = ent_q[issue_idx_s].r1.data;
        alu_r2_d   = ent_q[issue_idx_s].r2.data;
        alu_imm_d  = ent_q[issue_idx_s].imm;
        alu_pc_d   = ent_q[issue_idx_s].pc;
        alu_dest_d = ent_q[issue_idx_s].dest;
      end else begin
        alu_en_d = Disable;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        cnt_s = cnt_s + CNT_W'(ent_d[i].busy);
      end
      full_d = (cnt_s >= CNT_W'(RS_SIZE - 1));
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ent_q      <= ent_rst_s;
      alu_en_q   <= Disable;
      alu_op_q   <= '0;
      alu_r1_q   <= '0;
      alu_r2_q   <= '0;
      alu_imm_q  <= '0;
      alu_pc_q   <= '0;
      alu_dest_q <= '0;
      full_q     <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      alu_en_q   <= alu_en_d;
      alu_op_q   <= alu_op_d;
      alu_r1_q   <= alu_r1_d;
      alu_r2_q   <= alu_r2_d;
      alu_imm_q  <= alu_imm_d;
      alu_pc_q   <= alu_pc_d;
      alu_dest_q <= alu_dest_d;
      full_q     <= full_d;
    end
  end

  assign full_out         = full_q;
  assign ALU_enable       = alu_en_q;
  assign ALU_op           = alu_op_q;
  assign ALU_reg1         = alu_r1_q;
  assign ALU_reg2         = alu_r2_q;
  assign ALU_imm          = alu_imm_q;
  assign ALU_pc           = alu_pc_q;
  assign ALU_reg_dest_tag = alu_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed-vector bench for alu_rs with hand-computed expectations.
module tb_alu_rs;
  import cpu_define::*;

  logic   clk_in = 1'b0;
  logic   rst_in, rdy_in, clear_in;
  logic   DP_enable, DP_reg1_valid, DP_reg2_valid;
  OPBus   DP_op;
  DataBus DP_imm, DP_pc, DP_reg1_data, DP_reg2_data;
  TagBus  DP_reg1_tag, DP_reg2_tag, DP_reg_dest_tag;
  logic   full_out;
  logic   CDB_ALU_valid, CDB_LSB_valid;
  TagBus  CDB_ALU_tag, CDB_LSB_tag;
  DataBus CDB_ALU_data, CDB_LSB_data;
  logic   ALU_enable;
  OPBus   ALU_op;
  DataBus ALU_reg1, ALU_reg2, ALU_imm, ALU_pc;
  TagBus  ALU_reg_dest_tag;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  alu_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .DP_enable(DP_enable), .DP_op(DP_op), .DP_imm(DP_imm), .DP_pc(DP_pc),
    .DP_reg1_valid(DP_reg1_valid), .DP_reg1_data(DP_reg1_data), .DP_reg1_tag(DP_reg1_tag),
    .DP_reg2_valid(DP_reg2_valid), .DP_reg2_data(DP_reg2_data), .DP_reg2_tag(DP_reg2_tag),
    .DP_reg_dest_tag(DP_reg_dest_tag), .full_out(full_out),
    .CDB_ALU_valid(CDB_ALU_valid), .CDB_ALU_tag(CDB_ALU_tag), .CDB_ALU_data(CDB_ALU_data),
    .CDB_LSB_valid(CDB_LSB_valid), .CDB_LSB_tag(CDB_LSB_tag), .CDB_LSB_data(CDB_LSB_data),
    .ALU_enable(ALU_enable), .ALU_op(ALU_op), .ALU_reg1(ALU_reg1), .ALU_reg2(ALU_reg2),
    .ALU_imm(ALU_imm), .ALU_pc(ALU_pc), .ALU_reg_dest_tag(ALU_reg_dest_tag)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    DP_enable     = 1'b0;
    CDB_ALU_valid = 1'b0;
    CDB_LSB_valid = 1'b0;
    clear_in      = 1'b0;
  endtask

  task automatic dp(input logic [5:0] op, input logic v1, input logic [31:0] d1, input logic [4:0] t1,
                    input logic v2, input logic [31:0] d2, input logic [4:0] t2, input logic [4:0] dest);
    DP_enable       = 1'b1;
    DP_op           = op;
    DP_reg1_valid   = v1;
    DP_reg1_data    = d1;
    DP_reg1_tag     = t1;
    DP_reg2_valid   = v2;
    DP_reg2_data    = d2;
    DP_reg2_tag     = t2;
    DP_reg_dest_tag = dest;
    DP_imm          = {27'd0, dest} | 32'h0000_0100;
    DP_pc           = {16'h1000, 11'd0, dest};
  endtask

  task automatic cdb_alu(input logic [4:0] tag, input logic [31:0] data);
    CDB_ALU_valid = 1'b1;
    CDB_ALU_tag   = tag;
    CDB_ALU_data  = data;
  endtask

  task automatic cdb_lsb(input logic [4:0] tag, input logic [31:0] data);
    CDB_LSB_valid = 1'b1;
    CDB_LSB_tag   = tag;
    CDB_LSB_data  = data;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    DP_enable = 1'b0; DP_op = '0; DP_imm = '0; DP_pc = '0;
    DP_reg1_valid = 1'b0; DP_reg1_data = '0; DP_reg1_tag = '0;
    DP_reg2_valid = 1'b0; DP_reg2_data = '0; DP_reg2_tag = '0; DP_reg_dest_tag = '0;
    CDB_ALU_valid = 1'b0; CDB_ALU_tag = '0; CDB_ALU_data = '0;
    CDB_LSB_valid = 1'b0; CDB_LSB_tag = '0; CDB_LSB_data = '0;

    // Reset, with a dispatch request that must be ignored.
    dp(OP_ADD, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0, 5'd31);
    step(); step();
    idle();
    check_eq("rst_en", 32'(ALU_enable), 32'd0);
    check_eq("rst_full", 32'(full_out), 32'd0);
    check_eq("rst_reg1", ALU_reg1, 32'd0);
    check_eq("rst_pc", ALU_pc, 32'd0);
    check_eq("rst_dest", 32'(ALU_reg_dest_tag), 32'd0);
    rst_in = 1'b1;
    step(); step();
    check_eq("rst_no_issue", 32'(ALU_enable), 32'd0);

    // Both operands ready: ALU_enable exactly two edges after insert.
    dp(OP_ADD, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 5'd1);
    step(); idle();
    check_eq("add_lat1", 32'(ALU_enable), 32'd0);
    step();
    check_eq("add_en", 32'(ALU_enable), 32'd1);
    check_eq("add_r1", ALU_reg1, 32'd5);
    check_eq("add_r2", ALU_reg2, 32'd7);
    check_eq("add_op", 32'(ALU_op), 32'd1);
    check_eq("add_dest", 32'(ALU_reg_dest_tag), 32'd1);
    check_eq("add_pc", ALU_pc, 32'h1000_0001);
    check_eq("add_imm", ALU_imm, 32'h0000_0101);
    step();
    check_eq("add_once", 32'(ALU_enable), 32'd0);

    // reg1 woken by CDB_ALU two cycles after insert.
    dp(OP_ADD, 1'b0, 32'd0, 5'd3, 1'b1, 32'd9, 5'd0, 5'd2);
    step(); idle();
    step();
    check_eq("wake_wait", 32'(ALU_enable), 32'd0);
    cdb_alu(5'd3, 32'h10);
    step(); idle();
    check_eq("wake_edge", 32'(ALU_enable), 32'd0);
    step();
    check_eq("wake_en", 32'(ALU_enable), 32'd1);
    check_eq("wake_r1", ALU_reg1, 32'h10);
    check_eq("wake_r2", ALU_reg2, 32'd9);
    step();

    // reg2 captured from CDB_LSB in the insert cycle.
    dp(OP_SUB, 1'b1, 32'd1, 5'd0, 1'b0, 32'd0, 5'd6, 5'd4);
    cdb_lsb(5'd6, 32'hABCD);
    step(); idle();
    check_eq("byp_lat1", 32'(ALU_enable), 32'd0);
    step();
    check_eq("byp_en", 32'(ALU_enable), 32'd1);
    check_eq("byp_r2", ALU_reg2, 32'hABCD);
    check_eq("byp_dest", 32'(ALU_reg_dest_tag), 32'd4);
    step();

    // Tag Null never matches, at insert or later.
    dp(OP_ADD, 1'b0, 32'd0, 5'd0, 1'b1, 32'd1, 5'd0, 5'd5);
    cdb_alu(5'd0, 32'h77);
    step(); idle();
    cdb_alu(5'd0, 32'h77);
    step(); idle();
    check_eq("null_e1", 32'(ALU_enable), 32'd0);
    step();
    check_eq("null_e2", 32'(ALU_enable), 32'd0);
    step();
    check_eq("null_e3", 32'(ALU_enable), 32'd0);
    clear_in = 1'b1;
    step(); idle();

    // Two wakeups on both buses in one cycle, plus an insert alongside the issue.
    dp(OP_XOR, 1'b0, 32'd0, 5'd4, 1'b1, 32'd2, 5'd0, 5'd7);
    step();
    dp(OP_XOR, 1'b1, 32'd3, 5'd0, 1'b0, 32'd0, 5'd5, 5'd8);
    step(); idle();
    cdb_alu(5'd4, 32'h40);
    cdb_lsb(5'd5, 32'h50);
    step(); idle();
    check_eq("dual_pre", 32'(ALU_enable), 32'd0);
    dp(OP_ADD, 1'b1, 32'h61, 5'd0, 1'b1, 32'h62, 5'd0, 5'd9);
    step(); idle();
    check_eq("dual_en0", 32'(ALU_enable), 32'd1);
    check_eq("dual_dest0", 32'(ALU_reg_dest_tag), 32'd7);
    check_eq("dual_r1", ALU_reg1, 32'h40);
    step();
    check_eq("dual_dest1", 32'(ALU_reg_dest_tag), 32'd8);
    check_eq("dual_r2", ALU_reg2, 32'h50);
    step();
    check_eq("reuse_dest", 32'(ALU_reg_dest_tag), 32'd9);
    check_eq("reuse_r1", ALU_reg1, 32'h61);
    step();
    check_eq("dual_done", 32'(ALU_enable), 32'd0);

    // Fill all 16 entries with blocked ops; entries 0 and 1 wait on tag 8.
    for (int i = 0; i < 16; i++) begin
      dp(OP_ADD, 1'b0, 32'd0, (i < 2) ? 5'd8 : 5'd9, 1'b1, 32'(i), 5'd0, 5'(10 + i));
      step();
      if (i == 13) check_eq("full_at14", 32'(full_out), 32'd0);
      if (i == 14) check_eq("full_at15", 32'(full_out), 32'd1);
    end
    dp(OP_ADD, 1'b1, 32'hEE, 5'd0, 1'b1, 32'hEE, 5'd0, 5'd30);
    step(); idle();
    check_eq("full_at16", 32'(full_out), 32'd1);
    check_eq("ovf_en1", 32'(ALU_enable), 32'd0);
    step();
    check_eq("ovf_en2", 32'(ALU_enable), 32'd0);
    cdb_alu(5'd8, 32'h55);
    step(); idle();
    check_eq("fw_pre", 32'(ALU_enable), 32'd0);
    step();
    check_eq("fw_en0", 32'(ALU_enable), 32'd1);
    check_eq("fw_r1", ALU_reg1, 32'h55);
    check_eq("fw_dest0", 32'(ALU_reg_dest_tag), 32'd10);
    check_eq("fw_full15", 32'(full_out), 32'd1);
    step();
    check_eq("fw_dest1", 32'(ALU_reg_dest_tag), 32'd11);
    check_eq("fw_full14", 32'(full_out), 32'd0);
    step();
    check_eq("fw_idle", 32'(ALU_enable), 32'd0);
    clear_in = 1'b1;
    step(); idle();
    check_eq("fw_clr_full", 32'(full_out), 32'd0);

    // Clear with 8 busy entries and a simultaneous ready insert.
    for (int i = 0; i < 8; i++) begin
      dp(OP_ADD, 1'b0, 32'd0, 5'd12, 1'b1, 32'd0, 5'd0, 5'(i + 1));
      step();
    end
    idle();
    clear_in = 1'b1;
    dp(OP_ADD, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0, 5'd20);
    step(); idle();
    check_eq("clr_full", 32'(full_out), 32'd0);
    check_eq("clr_en1", 32'(ALU_enable), 32'd0);
    step();
    check_eq("clr_en2", 32'(ALU_enable), 32'd0);
    cdb_alu(5'd12, 32'd1);
    step(); idle();
    check_eq("clr_en3", 32'(ALU_enable), 32'd0);
    step();
    check_eq("clr_en4", 32'(ALU_enable), 32'd0);
    for (int i = 0; i < 14; i++) begin
      dp(OP_ADD, 1'b0, 32'd0, 5'd13, 1'b1, 32'd0, 5'd0, 5'd2);
      step();
    end
    idle();
    check_eq("clr_cnt0", 32'(full_out), 32'd0);
    clear_in = 1'b1;
    step(); idle();

    // rdy_in low for three cycles holds a ready entry.
    dp(OP_ADD, 1'b1, 32'd3, 5'd0, 1'b1, 32'd4, 5'd0, 5'd9);
    step(); idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("frz_en", 32'(ALU_enable), 32'd0);
    end
    rdy_in = 1'b1;
    step();
    check_eq("frz_issue", 32'(ALU_enable), 32'd1);
    check_eq("frz_r1", ALU_reg1, 32'd3);
    check_eq("frz_dest", 32'(ALU_reg_dest_tag), 32'd9);
    step();
    check_eq("frz_once", 32'(ALU_enable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
